div_request_issuer: RTL and testbench

DIV_REQUEST_ISSUER -- requirements
Module: div_request_issuer

---
 rtl/div_request_issuer.sv | 146 ++++++++++++++
 tb/tb_div_request_issuer.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/div_request_issuer.sv
// Front end for a multi-cycle divider. Requests are queued in a small FIFO and
// issued one at a time. Divide-by-zero requests are answered locally.
module div_request_issuer #(
  parameter int width = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [width-1:0]         in_dividend,
  input  logic [width-1:0]         in_divisor,
  output logic                     div_valid_in,
  output logic [width-1:0]         div_dividend,
  output logic [width-1:0]         div_divisor,
  input  logic                     div_valid_out,
  input  logic [width-1:0]         div_quotient,
  input  logic [width-1:0]         div_remainder,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [width-1:0]         res_quotient,
  output logic [width-1:0]         res_remainder,
  output logic                     res_div_by_zero,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] HOLD  = 2'd3;

  logic [width-1:0] r_mem_a [DEPTH];
  logic [width-1:0] r_mem_b [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic [1:0]       r_state;

  logic             r_div_valid_in;
  logic [width-1:0] r_div_dividend;
  logic [width-1:0] r_div_divisor;
  logic             r_res_valid;
  logic [width-1:0] r_res_quotient;
  logic [width-1:0] r_res_remainder;
  logic             r_res_dbz;

  logic             w_push;
  logic             w_pop;
  logic [width-1:0] w_head_a;
  logic [width-1:0] w_head_b;

  assign in_ready = (r_count < DEPTH_C);
  assign w_push   = in_valid && in_ready;
  // Only the idle FSM may take the head, which keeps a single division in flight.
  assign w_pop    = (r_state == IDLE) && (r_count != '0);
  assign w_head_a = r_mem_a[r_rd_ptr];
  assign w_head_b = r_mem_b[r_rd_ptr];

  // Request FIFO storage
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_a[r_wr_ptr] <= in_dividend;
      r_mem_b[r_wr_ptr] <= in_divisor;
    end
  end

  // Request FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Issue / wait / hold sequencing
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state         <= IDLE;
      r_div_valid_in  <= 1'b0;
      r_div_dividend  <= '0;
      r_div_divisor   <= '0;
      r_res_valid     <= 1'b0;
      r_res_quotient  <= '0;
      r_res_remainder <= '0;
      r_res_dbz       <= 1'b0;
    end else begin
      r_div_valid_in <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_pop) begin
            if (w_head_b != '0) begin
              r_div_dividend <= w_head_a;
              r_div_divisor  <= w_head_b;
              r_div_valid_in <= 1'b1;
              r_state        <= ISSUE;
            end else begin
              r_res_quotient  <= '1;
              r_res_remainder <= w_head_a;
              r_res_dbz       <= 1'b1;
              r_res_valid     <= 1'b1;
              r_state         <= HOLD;
            end
          end
        end
        ISSUE: r_state <= WAIT;
        WAIT: begin
          if (div_valid_out) begin
            r_res_quotient  <= div_quotient;
            r_res_remainder <= div_remainder;
            r_res_dbz       <= 1'b0;
            r_res_valid     <= 1'b1;
            r_state         <= HOLD;
          end
        end
        default: begin
          if (res_ready) begin
            r_res_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
      endcase
    end
  end

  assign div_valid_in    = r_div_valid_in;
  assign div_dividend    = r_div_dividend;
  assign div_divisor     = r_div_divisor;
  assign res_valid       = r_res_valid;
  assign res_quotient    = r_res_quotient;
  assign res_remainder   = r_res_remainder;
  assign res_div_by_zero = r_res_dbz;
  assign count           = r_count;

endmodule

// File: tb/tb_div_request_issuer.sv
// Scoreboard bench for div_request_issuer with a behavioural divider that
// answers each start pulse after a programmable latency.
module tb_div_request_issuer;
  localparam int W = 16;
  localparam int D = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 reset, in_valid, in_ready;
  logic [W-1:0]         in_dividend, in_divisor;
  logic                 div_valid_in, div_valid_out;
  logic [W-1:0]         div_dividend, div_divisor, div_quotient, div_remainder;
  logic                 res_valid, res_ready, res_div_by_zero;
  logic [W-1:0]         res_quotient, res_remainder;
  logic [$clog2(D):0]   count;

  div_request_issuer #(.width(W), .DEPTH(D)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_dividend(in_dividend), .in_divisor(in_divisor),
    .div_valid_in(div_valid_in), .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_valid_out(div_valid_out), .div_quotient(div_quotient), .div_remainder(div_remainder),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_quotient(res_quotient), .res_remainder(res_remainder),
    .res_div_by_zero(res_div_by_zero), .count(count)
  );

  typedef struct packed {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
  } res_t;

  res_t            sb[$];
  logic [2*W-1:0]  iss_q[$];
  int n_chk = 0, n_err = 0, n_issue = 0, n_res = 0;
  int div_lat = 3, dly = 0;
  bit div_abort = 1'b0;
  logic [W-1:0] dq, dr, hold_a, hold_b;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [W-1:0] a, input logic [W-1:0] b);
    res_t e;
    for (int i = 0; i < 200 && !in_ready; i++) tick();
    check("push_ready", in_ready, 1);
    in_valid = 1'b1; in_dividend = a; in_divisor = b;
    e.q   = (b != 0) ? a / b : '1;
    e.r   = (b != 0) ? a % b : a;
    e.dbz = (b == 0);
    sb.push_back(e);
    if (b != 0) iss_q.push_back({a, b});
    tick();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 400; i++) begin
      done = (sb.size() == 0) && (iss_q.size() == 0) && !res_valid && (count == 0);
      if (done) break;
      tick();
    end
    check("drain", done, 1);
  endtask

  // Behavioural divider: checks the issued operands, holds them under watch, answers later
  initial begin
    logic [2*W-1:0] op;
    div_valid_out = 1'b0; div_quotient = '0; div_remainder = '0;
    forever begin
      @(negedge clk);
      div_valid_out = 1'b0;
      if (dly > 0) begin
        if (!div_abort) begin
          check("op_stable_a", div_dividend, hold_a);
          check("op_stable_b", div_divisor, hold_b);
        end
        dly--;
        if (dly == 0) begin
          div_valid_out = 1'b1; div_quotient = dq; div_remainder = dr;
        end
      end
      if (div_valid_in) begin
        n_issue++;
        check("issue_pending", iss_q.size() != 0, 1);
        if (iss_q.size() != 0) begin
          op = iss_q.pop_front();
          check("issue_a", div_dividend, op[2*W-1:W]);
          check("issue_b", div_divisor, op[W-1:0]);
        end
        hold_a = div_dividend; hold_b = div_divisor;
        dq = (div_divisor != 0) ? div_dividend / div_divisor : '1;
        dr = (div_divisor != 0) ? div_dividend % div_divisor : div_dividend;
        dly = div_lat;
        div_abort = 1'b0;
      end
    end
  end

  // Result monitor: every accepted result is compared with the scoreboard head
  initial begin
    res_t e;
    forever begin
      @(negedge clk);
      if (!reset && res_valid && res_ready) begin
        n_res++;
        check("res_pending", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("res_q", res_quotient, e.q);
          check("res_r", res_remainder, e.r);
          check("res_dbz", res_div_by_zero, e.dbz);
        end
      end
    end
  end

  initial begin
    int base, base_res;
    reset = 1'b1; in_valid = 1'b1; in_dividend = 16'd9; in_divisor = 16'd4; res_ready = 1'b1;
    repeat (3) tick();
    in_valid = 1'b0;
    reset = 1'b0;
    check("rst_count", count, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_div_valid_in", div_valid_in, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_dbz", res_div_by_zero, 0);
    check("rst_res_q", res_quotient, 0);
    check("rst_res_r", res_remainder, 0);
    check("rst_div_a", div_dividend, 0);
    check("rst_div_b", div_divisor, 0);

    // 100 / 7 with latency check
    base = n_issue;
    push(16'd100, 16'd7);
    check("lat_early", div_valid_in, 0);
    tick();
    check("lat_issue", div_valid_in, 1);
    check("lat_op_a", div_dividend, 100);
    tick();
    check("issue_one_cycle", div_valid_in, 0);
    drain();
    check("t1_issues", n_issue - base, 1);

    // 55 / 0 answered locally
    base = n_issue;
    push(16'd55, 16'd0);
    tick();
    check("dbz_res_valid", res_valid, 1);
    check("dbz_q", res_quotient, 16'hFFFF);
    check("dbz_r", res_remainder, 55);
    check("dbz_flag", res_div_by_zero, 1);
    drain();
    check("dbz_no_issue", n_issue - base, 0);

    // Backpressure: fill FIFO, sixth request refused
    res_ready = 1'b0;
    base_res = n_res;
    for (int i = 0; i < 5; i++) push(16'(200 + 13*i), 16'(3 + i));
    check("full_count", count, 4);
    check("full_in_ready", in_ready, 0);
    in_valid = 1'b1; in_dividend = 16'd77; in_divisor = 16'd7;
    tick();
    in_valid = 1'b0;
    check("full_count_after", count, 4);
    res_ready = 1'b1;
    drain();
    check("full_results", n_res - base_res, 5);

    // Held result stays stable and blocks the next issue
    res_ready = 1'b0;
    push(16'd9, 16'd3);
    push(16'd20, 16'd6);
    for (int i = 0; i < 50 && !res_valid; i++) tick();
    check("hold_res_valid", res_valid, 1);
    base = n_issue;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("hold_valid", res_valid, 1);
      check("hold_q", res_quotient, 3);
      check("hold_r", res_remainder, 0);
    end
    check("hold_no_issue", n_issue - base, 0);
    res_ready = 1'b1;
    drain();

    // Reset while waiting on the divider; its late completion must be ignored
    div_lat = 8;
    push(16'd50, 16'd5);
    for (int i = 0; i < 20 && !div_valid_in; i++) tick();
    check("rw_issue", div_valid_in, 1);
    tick(); tick();
    reset = 1'b1; div_abort = 1'b1;
    tick();
    reset = 1'b0;
    sb.delete(); iss_q.delete();
    for (int i = 0; i < 12; i++) begin
      tick();
      check("rw_res_valid", res_valid, 0);
    end
    check("rw_count", count, 0);
    check("rw_in_ready", in_ready, 1);
    div_lat = 3;
    push(16'd100, 16'd7);
    drain();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
